// File: rtl/conv2_dw_window.sv
// conv2_dw_window: 3x3 sliding-window generator for a raster pixel stream
// (all CH channels carried side by side), valid convolution, stride 1 or 2.
// Latency: window emitted 1 cycle after its bottom-right pixel; no backpressure.
// Ports: clk/rstn (async active-low), in_valid/in_sof/in_pixel in,
//        out_valid/out_window (registered, held between windows), frame_done pulse.
module conv2_dw_window #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int CH     = 8,
  parameter int DW     = 16,
  parameter int STRIDE = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [CH*DW-1:0]   in_pixel,
  output logic               out_valid,
  output logic [CH*9*DW-1:0] out_window,
  output logic               frame_done
);

  localparam int PW = CH * DW;
  localparam int WW = CH * 9 * DW;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Position counters of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;

  // lb0 holds row r-2, lb1 holds row r-1 (relative to the incoming row).
  logic [PW-1:0] lb0_q [IMG_W];
  logic [PW-1:0] lb1_q [IMG_W];

  // Window register, indexed [dy][dx]; column 2 is the newest column.
  logic [PW-1:0] win_q [3][3];
  logic [PW-1:0] win_d [3][3];

  logic [WW-1:0] win_flat;
  logic [WW-1:0] out_window_q;
  logic          out_valid_q;
  logic          frame_done_q;
  logic          emit;
  logic          done;
  logic          last_col;
  logic          last_row;
  logic          stride_ok;

  always_comb begin
    // A start-of-frame pixel is (0,0) regardless of where the counters are.
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;

    last_col = (col_cur == COL_LAST);
    last_row = (row_cur == ROW_LAST);
    col_d    = last_col ? '0 : col_cur + 1'b1;
    row_d    = row_cur;
    if (last_col) begin
      row_d = last_row ? '0 : row_cur + 1'b1;
    end

    // Shift the window left and bring in the column ending at this pixel.
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        win_d[dy][dx] = win_q[dy][dx];
      end
    end
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        win_d[dy][dx] = win_q[dy][dx+1];
      end
    end
    win_d[0][2] = lb0_q[col_cur];
    win_d[1][2] = lb1_q[col_cur];
    win_d[2][2] = in_pixel;

    // Top-left (r-2,c-2) must be on the stride grid; with STRIDE 2 that is
    // simply "r and c even". Requiring row>=2 after a counter reset (sof or
    // rstn) guarantees both line buffers were refilled in this frame, and
    // col>=2 guarantees the window never straddles a row wrap.
    stride_ok = (STRIDE == 1) || (!row_cur[0] && !col_cur[0]);
    emit      = in_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2)) && stride_ok;
    done      = in_valid && last_col && last_row;

    win_flat = '0;
    for (int k = 0; k < CH; k++) begin
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          win_flat[(9*k + 3*dy + dx)*DW +: DW] = win_d[dy][dx][k*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_window_q <= '0;
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          win_q[dy][dx] <= '0;
        end
      end
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= done;
      if (emit) begin
        out_window_q <= win_flat;
      end
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        for (int dy = 0; dy < 3; dy++) begin
          for (int dx = 0; dx < 3; dx++) begin
            win_q[dy][dx] <= win_d[dy][dx];
          end
        end
      end
    end
  end

  // Line buffers are never cleared: stale entries are overwritten before
  // any emitted window can read them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0_q[col_cur] <= lb1_q[col_cur];
      lb1_q[col_cur] <= in_pixel;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/conv2_dw_window.md
CONV2_DW_WINDOW -- requirements
Module: conv2_dw_window

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16: frame width in pixels, minimum 3.
REQ-002 The block SHALL have parameter IMG_H, default 16: frame height in pixels, minimum 3.
REQ-003 The block SHALL have parameter CH, default 8: channels per pixel.
REQ-004 The block SHALL have parameter DW, default 16: bits per channel sample.
REQ-005 The block SHALL have parameter STRIDE, default 1: window stride, legal values 1 and 2.
REQ-006 The block SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_pixel is accepted this cycle.
REQ-009 The block SHALL have port in_sof, input, 1 bit: start of frame, qualified by in_valid.
REQ-010 The block SHALL have port in_pixel, input, CH*DW bits: one pixel; channel k at [DW*k+DW-1 : DW*k].
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_window holds a new window this cycle.
REQ-012 The block SHALL have port out_window, output, CH*9*DW bits (1152 at defaults): a 3x3 window for every channel.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-014 The block SHALL accept pixels in raster order (row 0 first, column 0 first within each row) with no backpressure; cycles with in_valid=0 change no state.
REQ-015 The block SHALL track the position of each accepted pixel as (row, col); col SHALL wrap IMG_W-1->0 and increment row; row SHALL wrap IMG_H-1->0.
REQ-016 An accepted pixel with in_sof=1 SHALL be treated as (0,0) whatever the counter state; the old window contents SHALL be discarded and no window SHALL be produced from pixels before it.
REQ-017 The block SHALL store the two most recent complete rows in line buffers of IMG_W x CH*DW bits each, plus a 3x3xCH window register.
REQ-018 Windows SHALL use valid convolution with no padding; the window with top-left (r0,c0) SHALL cover rows r0..r0+2 and columns c0..c0+2.
REQ-019 The window with top-left (r0,c0) SHALL be emitted when pixel (r0+2,c0+2) is accepted, if r0 mod STRIDE = 0 and c0 mod STRIDE = 0.
REQ-020 The window SHALL be emitted the cycle after pixel (r0+2,c0+2) is accepted: out_valid=1 for exactly one cycle; latency is 1 cycle.
REQ-021 out_window SHALL be a register and SHALL hold its value while out_valid=0.
REQ-022 Packing SHALL be channel k in slice [144k+143 : 144k] (at DW=16); within that slice, tap t = 3*dy+dx at [16t+15 : 16t]; dy is the row offset 0..2 from top and dx the column offset 0..2 from left; t=0 is top-left, t=8 is bottom-right.
REQ-023 Each frame SHALL produce exactly ((IMG_H-3)/STRIDE+1) x ((IMG_W-3)/STRIDE+1) windows, integer division.
REQ-024 frame_done SHALL pulse the cycle after pixel (IMG_H-1, IMG_W-1) is accepted; it MAY coincide with out_valid.
REQ-025 Pixels at columns 0 and 1 of each row SHALL emit no window, so no window ever spans a row wrap.
REQ-026 Back-to-back frames with no idle cycles SHALL be supported, with or without in_sof.
REQ-027 Data SHALL pass through unmodified: no arithmetic, sign extension or truncation.

Reset
REQ-028 While rstn=0: out_valid=0, frame_done=0, out_window=0, row=0, col=0.
REQ-029 Line buffer contents MAY be left uncleared, because no window using them is emitted until they are rewritten (REQ-019).
REQ-030 Reset asserted mid-frame SHALL abort the frame; the first pixel accepted after release SHALL be (0,0).

Verification
REQ-031 Defaults with IMG_W=4, IMG_H=4, STRIDE=1; every channel of pixel (r,c) = 4r+c; 16 pixels streamed -> 4 windows, the first one cycle after pixel 10 with taps {0,1,2,4,5,6,8,9,10}, the last with taps {5,6,7,9,10,11,13,14,15}; frame_done one cycle after pixel 15.
REQ-032 Same frame with STRIDE=2 -> exactly 1 window, taps {0,1,2,4,5,6,8,9,10}.
REQ-033 Same frame with random in_valid gaps of 0-3 cycles -> identical window sequence; out_valid only in the cycle after an accepted pixel.
REQ-034 in_sof asserted on the 7th pixel of a frame, then 16 pixels -> no window from the earlier pixels; 4 correct windows from the new frame.
REQ-035 rstn pulsed low after pixel 9, then a full 4x4 frame -> no out_valid during or right after reset; 4 correct windows.
REQ-036 Channel k of pixel p = 256k+p at defaults, for a lane-order check -> channel k slice tap 0 equals 256k for the first window.
